// File: rtl/multi_pulse_pkg.sv
// Shared types and trigger decode for the multi-channel one-shot generator.
package multi_pulse_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    HOLD  = 2'd2,
    DEAD  = 2'd3
  } pulse_state_e;

  typedef enum logic [1:0] {
    MODE_LEVEL = 2'd0,
    MODE_RISE  = 2'd1,
    MODE_FALL  = 2'd2,
    MODE_BOTH  = 2'd3
  } edge_mode_e;

  function automatic logic trig_decode(edge_mode_e mode, logic x, logic x_q);
    logic t;
    unique case (mode)
      MODE_LEVEL: t = x;
      MODE_RISE:  t = x & ~x_q;
      MODE_FALL:  t = ~x & x_q;
      MODE_BOTH:  t = x ^ x_q;
      default:    t = 1'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/multi_pulse_if.sv
// Trigger/config/pulse bundle for multi_pulse; drop counter signals exist only with
// MULTI_PULSE_DROP_CNT_EN defined.
interface multi_pulse_if #(
  parameter int unsigned N_CH   = 4,
  parameter int unsigned LEN_W  = 4,
  parameter int unsigned HOLD_W = 4
`ifdef MULTI_PULSE_DROP_CNT_EN
  , parameter int unsigned CNT_W = 8
`endif
);
  logic [N_CH-1:0]   x;
  logic [1:0]        edge_mode;
  logic [LEN_W-1:0]  pulse_len;
  logic [HOLD_W-1:0] holdoff;
  logic [N_CH-1:0]   y;
  logic [N_CH-1:0]   busy;
`ifdef MULTI_PULSE_DROP_CNT_EN
  logic              drop_clr;
  logic [N_CH*CNT_W-1:0] drop_cnt;

  modport master (output x, edge_mode, pulse_len, holdoff, drop_clr,
                  input  y, busy, drop_cnt);
  modport slave  (input  x, edge_mode, pulse_len, holdoff, drop_clr,
                  output y, busy, drop_cnt);
`else
  modport master (output x, edge_mode, pulse_len, holdoff,
                  input  y, busy);
  modport slave  (input  x, edge_mode, pulse_len, holdoff,
                  output y, busy);
`endif
endinterface

// File: rtl/multi_pulse_chan.sv
// One one-shot channel: input history, IDLE/PULSE/HOLD/DEAD FSM, length and holdoff counters,
// and a saturating dropped-trigger counter when MULTI_PULSE_DROP_CNT_EN is defined.
module multi_pulse_chan
  import multi_pulse_pkg::*;
#(
  parameter int unsigned LEN_W  = 4,
  parameter int unsigned HOLD_W = 4
`ifdef MULTI_PULSE_DROP_CNT_EN
  , parameter int unsigned CNT_W = 8
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_x,
  input  logic [1:0]        i_edge_mode,
  input  logic [LEN_W-1:0]  i_pulse_len,
  input  logic [HOLD_W-1:0] i_holdoff,
`ifdef MULTI_PULSE_DROP_CNT_EN
  input  logic              i_drop_clr,
  output logic [CNT_W-1:0]  o_drop_cnt,
`endif
  output logic              o_y,
  output logic              o_busy
);

  pulse_state_e      r_state, w_state_d;
  logic              r_x_q;
  logic [LEN_W-1:0]  r_len_cnt, w_len_cnt_d;
  logic [HOLD_W-1:0] r_hold_l, w_hold_l_d;
  logic [HOLD_W-1:0] r_hold_cnt, w_hold_cnt_d;
  edge_mode_e        w_mode;
  logic              w_trig;

  assign w_mode = edge_mode_e'(i_edge_mode);
  assign w_trig = trig_decode(w_mode, i_x, r_x_q);

  always_comb begin
    w_state_d    = r_state;
    w_len_cnt_d  = r_len_cnt;
    w_hold_l_d   = r_hold_l;
    w_hold_cnt_d = r_hold_cnt;
    unique case (r_state)
      IDLE: begin
        if (w_trig) begin
          w_state_d   = PULSE;
          w_len_cnt_d = i_pulse_len;
          w_hold_l_d  = i_holdoff;
        end
      end
      PULSE: begin
        if (r_len_cnt != '0) begin
          w_len_cnt_d = r_len_cnt - LEN_W'(1);
        end else if (r_hold_l != '0) begin
          w_state_d    = HOLD;
          w_hold_cnt_d = r_hold_l - HOLD_W'(1);
        end else begin
          w_state_d = (w_mode == MODE_LEVEL) ? DEAD : IDLE;
        end
      end
      HOLD: begin
        if (r_hold_cnt != '0) begin
          w_hold_cnt_d = r_hold_cnt - HOLD_W'(1);
        end else begin
          w_state_d = (w_mode == MODE_LEVEL) ? DEAD : IDLE;
        end
      end
      DEAD: begin
        // Wait for the input to drop so a held level cannot retrigger.
        if (!i_x) w_state_d = IDLE;
      end
      default: w_state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_x_q      <= 1'b0;
      r_len_cnt  <= '0;
      r_hold_l   <= '0;
      r_hold_cnt <= '0;
    end else begin
      r_state    <= w_state_d;
      r_x_q      <= i_x;
      r_len_cnt  <= w_len_cnt_d;
      r_hold_l   <= w_hold_l_d;
      r_hold_cnt <= w_hold_cnt_d;
    end
  end

  assign o_y    = (r_state == PULSE);
  assign o_busy = (r_state != IDLE);

`ifdef MULTI_PULSE_DROP_CNT_EN
  logic             w_drop_inc;
  logic [CNT_W-1:0] r_drop_cnt;

  // A held level in DEAD is the same event that was already serviced; edges are new events.
  assign w_drop_inc = w_trig && ((r_state == PULSE) || (r_state == HOLD) ||
                                 ((r_state == DEAD) && (w_mode != MODE_LEVEL)));

  always_ff @(posedge clk) begin
    if (reset || i_drop_clr) begin
      r_drop_cnt <= '0;
    end else if (w_drop_inc && (r_drop_cnt != '1)) begin
      r_drop_cnt <= r_drop_cnt + CNT_W'(1);
    end
  end

  assign o_drop_cnt = r_drop_cnt;
`endif

endmodule

// File: rtl/multi_pulse.sv
// N-channel one-shot generator: one multi_pulse_chan per input bit sharing mode/length/holdoff.
// Optional drop counters enabled by MULTI_PULSE_DROP_CNT_EN.
module multi_pulse
  import multi_pulse_pkg::*;
#(
  parameter int unsigned N_CH   = 4,
  parameter int unsigned LEN_W  = 4,
  parameter int unsigned HOLD_W = 4
`ifdef MULTI_PULSE_DROP_CNT_EN
  , parameter int unsigned CNT_W = 8
`endif
) (
  input logic          clk,
  input logic          reset,
  multi_pulse_if.slave bus
);

  for (genvar g = 0; g < N_CH; g++) begin : g_chan
    multi_pulse_chan #(
      .LEN_W (LEN_W),
      .HOLD_W(HOLD_W)
`ifdef MULTI_PULSE_DROP_CNT_EN
      , .CNT_W(CNT_W)
`endif
    ) u_chan (
      .clk        (clk),
      .reset      (reset),
      .i_x        (bus.x[g]),
      .i_edge_mode(bus.edge_mode),
      .i_pulse_len(bus.pulse_len),
      .i_holdoff  (bus.holdoff),
`ifdef MULTI_PULSE_DROP_CNT_EN
      .i_drop_clr (bus.drop_clr),
      .o_drop_cnt (bus.drop_cnt[g*CNT_W +: CNT_W]),
`endif
      .o_y        (bus.y[g]),
      .o_busy     (bus.busy[g])
    );
  end

endmodule

// File: tb/tb_multi_pulse.sv
// Self-checking bench for multi_pulse: directed scenarios plus random traffic against a
// timestamp-based reference model.
module tb_multi_pulse;
  localparam int N = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  multi_pulse_if u_if ();

  multi_pulse dut (
    .clk  (clk),
    .reset(reset),
    .bus  (u_if)
  );

  int n_cmp = 0;
  int n_mis = 0;

  // Reference model: each accepted trigger becomes a time window, not a state machine.
  int e = 0;
  bit act[N], dead[N], xq[N];
  int t_on[N], t_end[N], len_l[N], drop[N];

  task automatic check_eq(input string tag, input logic [31:0] act_v, input logic [31:0] exp_v);
    n_cmp++;
    if (act_v !== exp_v) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act_v, exp_v, e);
    end
  endtask

  task automatic model_step();
    bit xi, trig, inc, clr;
    int mode;
    e++;
    mode = int'(u_if.edge_mode);
`ifdef MULTI_PULSE_DROP_CNT_EN
    clr = u_if.drop_clr;
`else
    clr = 1'b0;
`endif
    for (int i = 0; i < N; i++) begin
      if (reset) begin
        act[i] = 0; dead[i] = 0; xq[i] = 0; drop[i] = 0;
        continue;
      end
      xi = u_if.x[i];
      case (mode)
        0: trig = xi;
        1: trig = xi && !xq[i];
        2: trig = !xi && xq[i];
        default: trig = xi != xq[i];
      endcase
      inc = 0;
      if (!act[i]) begin
        if (trig) begin
          act[i]   = 1;
          t_on[i]  = e;
          len_l[i] = int'(u_if.pulse_len);
          t_end[i] = e + int'(u_if.pulse_len) + int'(u_if.holdoff) + 1;
        end
      end else if (dead[i]) begin
        inc = trig && (mode != 0);
        if (!xi) begin act[i] = 0; dead[i] = 0; end
      end else begin
        inc = trig;
        if (e == t_end[i]) begin
          if (mode == 0) dead[i] = 1;
          else act[i] = 0;
        end
      end
      if (clr) drop[i] = 0;
      else if (inc && drop[i] < 255) drop[i]++;
      xq[i] = xi;
    end
  endtask

  task automatic check_outputs();
    logic [3:0] ey, eb;
    for (int i = 0; i < N; i++) begin
      ey[i] = act[i] && !dead[i] && (e <= t_on[i] + len_l[i]);
      eb[i] = act[i];
    end
    check_eq("y", 32'(u_if.y), 32'(ey));
    check_eq("busy", 32'(u_if.busy), 32'(eb));
`ifdef MULTI_PULSE_DROP_CNT_EN
    for (int i = 0; i < N; i++)
      check_eq($sformatf("drop_cnt%0d", i), 32'(u_if.drop_cnt[i*8 +: 8]), 32'(drop[i]));
`endif
  endtask

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      check_outputs();
    end
  endtask

  task automatic cfg(input logic [1:0] m, input logic [3:0] l, input logic [3:0] h);
    u_if.edge_mode = m;
    u_if.pulse_len = l;
    u_if.holdoff   = h;
  endtask

  initial begin
    reset = 1'b1;
    u_if.x = '0;
    cfg(2'd0, 4'd0, 4'd0);
`ifdef MULTI_PULSE_DROP_CNT_EN
    u_if.drop_clr = 1'b0;
`endif
    tick(2);
    check_eq("reset_y", 32'(u_if.y), 32'h0);
    reset = 1'b0;

    // 1: LEVEL one-shot, then DEAD until release
    u_if.x[0] = 1'b1;
    tick(10);
    u_if.x[0] = 1'b0;
    tick(3);

    // 2: RISE with holdoff; second rise lands inside the pulse
    cfg(2'd1, 4'd3, 4'd2);
    for (int k = 0; k < 4; k++) begin
      u_if.x[1] = ~k[0];
      tick();
    end
    u_if.x[1] = 1'b0;
    tick(10);

    // 3: BOTH edges
    cfg(2'd3, 4'd1, 4'd0);
    u_if.x[2] = 1'b1;
    tick(5);
    u_if.x[2] = 1'b0;
    tick(6);

    // 4: FALL with input held through reset
    cfg(2'd2, 4'd0, 4'd0);
    u_if.x[3] = 1'b1;
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(3);
    u_if.x[3] = 1'b0;
    tick(4);

    // 5: all channels at once, reset mid-pulse
    cfg(2'd1, 4'd2, 4'd0);
    u_if.x = 4'h0;
    tick(2);
    u_if.x = 4'hF;
    tick();
    check_eq("all_y", 32'(u_if.y), 32'hF);
    check_eq("all_busy", 32'(u_if.busy), 32'hF);
    tick();
    check_eq("all_y2", 32'(u_if.y), 32'hF);
    reset = 1'b1;
    tick();
    check_eq("rst_y", 32'(u_if.y), 32'h0);
    check_eq("rst_busy", 32'(u_if.busy), 32'h0);
    reset = 1'b0;
    u_if.x = 4'h0;
    tick(2);

`ifdef MULTI_PULSE_DROP_CNT_EN
    // 6: drop counter saturation and clear priority
    cfg(2'd1, 4'd15, 4'd0);
    for (int k = 0; k < 700; k++) begin
      u_if.x[0] = ~u_if.x[0];
      tick();
    end
    check_eq("drop_sat", 32'(u_if.drop_cnt[7:0]), 32'd255);
    u_if.x[0] = 1'b0;
    tick();
    u_if.x[0] = 1'b1;
    u_if.drop_clr = 1'b1;
    tick();
    u_if.drop_clr = 1'b0;
    check_eq("drop_clr", 32'(u_if.drop_cnt[7:0]), 32'd0);
    u_if.x[0] = 1'b0;
    tick(20);
`endif

    // Random traffic
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(15) == 0)
        cfg(2'($urandom_range(3)), 4'($urandom_range(15)), 4'($urandom_range(15)));
      for (int i = 0; i < N; i++)
        if ($urandom_range(3) == 0) u_if.x[i] = ~u_if.x[i];
      reset = ($urandom_range(199) == 0);
`ifdef MULTI_PULSE_DROP_CNT_EN
      u_if.drop_clr = ($urandom_range(49) == 0);
`endif
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
